// File: rtl/dna_pattern_matcher.sv
// Runtime-loadable nucleotide pattern detector. Accepts one-hot A/C/G/T strobes and
// reports matches, a saturating match count, an alarm and prefix progress for LEDs.
module dna_pattern_matcher #(
   parameter int                 LEN             = 4,
   parameter int                 CNT_W           = 8,
   parameter bit                 OVERLAP         = 1'b1,
   parameter logic [2*LEN-1:0]   DEFAULT_PATTERN = 8'h7A
) (
   input  logic                        i_w_clk,
   input  logic                        i_w_reset,
   input  logic                        i_w_A,
   input  logic                        i_w_G,
   input  logic                        i_w_C,
   input  logic                        i_w_T,
   input  logic                        i_w_load,
   input  logic [2*LEN-1:0]            i_w_pattern,
   input  logic                        i_w_sticky,
   output logic                        o_r_mutant,
   output logic                        o_r_match_pulse,
   output logic [CNT_W-1:0]            o_r_match_count,
   output logic [$clog2(LEN+1)-1:0]    o_r_progress,
   output logic                        o_r_error
);

   localparam int             PW   = $clog2(LEN+1);
   localparam int             HW   = 2*LEN;
   localparam logic [PW-1:0]  FULL = PW'(LEN);

   logic [HW-1:0] pattern_r, hist_r, hist_nxt;
   logic [PW-1:0] fill_r, fill_nxt, prog_calc;
   logic [3:0]    strobes;
   logic [1:0]    sym;
   logic          one_sym, multi, match, ok;

   assign strobes = {i_w_T, i_w_G, i_w_C, i_w_A};
   assign one_sym = $onehot(strobes);
   assign multi   = (|strobes) && !one_sym;

   always_comb begin
      sym = 2'b00;
      case (strobes)
         4'b0010: sym = 2'b01;
         4'b0100: sym = 2'b10;
         4'b1000: sym = 2'b11;
         default: sym = 2'b00;
      endcase
   end

   // Newest symbol enters at the top; the oldest sits in [1:0] so a full
   // history lines up directly against the pattern register.
   assign hist_nxt = {sym, hist_r[HW-1:2]};
   assign fill_nxt = (fill_r == FULL) ? FULL : fill_r + PW'(1);
   assign match    = (fill_nxt == FULL) && (hist_nxt == pattern_r);

   // Longest proper prefix of the pattern that ends the history (KMP border
   // once a full match is present, since k stops at LEN-1).
   always_comb begin
      prog_calc = '0;
      ok        = 1'b0;
      for (int k = 1; k < LEN; k++) begin
         ok = (PW'(k) <= fill_nxt);
         for (int j = 0; j < k; j++)
            if (hist_nxt[2*(LEN-k+j) +: 2] != pattern_r[2*j +: 2]) ok = 1'b0;
         if (ok) prog_calc = PW'(k);
      end
   end

   always_ff @(posedge i_w_clk or posedge i_w_reset) begin
      if (i_w_reset) begin
         pattern_r       <= DEFAULT_PATTERN;
         hist_r          <= '0;
         fill_r          <= '0;
         o_r_mutant      <= 1'b0;
         o_r_match_pulse <= 1'b0;
         o_r_match_count <= '0;
         o_r_progress    <= '0;
         o_r_error       <= 1'b0;
      end else if (i_w_load) begin
         pattern_r       <= i_w_pattern;
         hist_r          <= '0;
         fill_r          <= '0;
         o_r_mutant      <= 1'b0;
         o_r_match_pulse <= 1'b0;
         o_r_match_count <= '0;
         o_r_progress    <= '0;
         o_r_error       <= 1'b0;
      end else begin
         o_r_match_pulse <= 1'b0;
         o_r_error       <= 1'b0;
         // Pulse-mode alarm follows the match pulse; sticky mode only ever sets.
         if (!i_w_sticky) o_r_mutant <= 1'b0;
         if (multi) begin
            hist_r       <= '0;
            fill_r       <= '0;
            o_r_progress <= '0;
            o_r_error    <= 1'b1;
         end else if (one_sym) begin
            o_r_match_pulse <= match;
            if (match) begin
               o_r_mutant <= 1'b1;
               if (o_r_match_count != '1) o_r_match_count <= o_r_match_count + CNT_W'(1);
            end
            if (match && !OVERLAP) begin
               hist_r       <= '0;
               fill_r       <= '0;
               o_r_progress <= '0;
            end else begin
               hist_r       <= hist_nxt;
               fill_r       <= fill_nxt;
               o_r_progress <= prog_calc;
            end
         end
      end
   end

endmodule

// File: tb/tb_dna_pattern_matcher.sv
// Bench for dna_pattern_matcher: three instances (overlap, non-overlap, 2-bit counter)
// driven in parallel against a symbol-list reference model and a tagged scoreboard.
module tb_dna_pattern_matcher;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sa = 0, sg = 0, sc = 0, st = 0, load = 0, sticky = 1;
   logic [7:0] pattern = '0;

   logic [2:0]      mut, pulse, err;
   logic [2:0][2:0] prog;
   logic [7:0]      cnt0, cnt1;
   logic [1:0]      cnt2;
   logic [2:0][7:0] acnt;

   assign acnt[0] = cnt0;
   assign acnt[1] = cnt1;
   assign acnt[2] = {6'b0, cnt2};

   always #5 clk = ~clk;

   dna_pattern_matcher #(.LEN(4), .CNT_W(8), .OVERLAP(1'b1)) dut_ovl (
      .i_w_clk(clk), .i_w_reset(rst), .i_w_A(sa), .i_w_G(sg), .i_w_C(sc), .i_w_T(st),
      .i_w_load(load), .i_w_pattern(pattern), .i_w_sticky(sticky),
      .o_r_mutant(mut[0]), .o_r_match_pulse(pulse[0]), .o_r_match_count(cnt0),
      .o_r_progress(prog[0]), .o_r_error(err[0]));

   dna_pattern_matcher #(.LEN(4), .CNT_W(8), .OVERLAP(1'b0)) dut_novl (
      .i_w_clk(clk), .i_w_reset(rst), .i_w_A(sa), .i_w_G(sg), .i_w_C(sc), .i_w_T(st),
      .i_w_load(load), .i_w_pattern(pattern), .i_w_sticky(sticky),
      .o_r_mutant(mut[1]), .o_r_match_pulse(pulse[1]), .o_r_match_count(cnt1),
      .o_r_progress(prog[1]), .o_r_error(err[1]));

   dna_pattern_matcher #(.LEN(4), .CNT_W(2), .OVERLAP(1'b1)) dut_sat (
      .i_w_clk(clk), .i_w_reset(rst), .i_w_A(sa), .i_w_G(sg), .i_w_C(sc), .i_w_T(st),
      .i_w_load(load), .i_w_pattern(pattern), .i_w_sticky(sticky),
      .o_r_mutant(mut[2]), .o_r_match_pulse(pulse[2]), .o_r_match_count(cnt2),
      .o_r_progress(prog[2]), .o_r_error(err[2]));

   typedef struct packed {
      int              tag;
      logic [2:0]      mut, pulse, err;
      logic [2:0][2:0] prog;
      logic [2:0][7:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cycnt = 0;
   int   checks = 0, failures = 0;

   // reference model: explicit list of accepted symbols, oldest first
   logic [7:0] m_pat[3];
   int         m_s[3][4];
   int         m_n[3], m_cnt[3], m_prog[3];
   int         m_max[3] = '{255, 255, 3};
   bit         m_ovl[3] = '{1'b1, 1'b0, 1'b1};
   bit         m_mut[3], m_pulse[3], m_err[3];

   always @(posedge clk) cycnt <= cycnt + 1;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_pat[i] = 8'h7A; m_n[i] = 0; m_cnt[i] = 0; m_prog[i] = 0;
         m_mut[i] = 0; m_pulse[i] = 0; m_err[i] = 0;
      end
   endtask

   task automatic model_step(input bit [3:0] stb, input bit ld, input logic [7:0] pat,
                             input bit stk);
      int  n, sym, lim;
      bit  hit, ok;
      n = $countones(stb);
      for (int i = 0; i < 3; i++) begin
         if (ld) begin
            m_pat[i] = pat; m_n[i] = 0; m_cnt[i] = 0; m_prog[i] = 0;
            m_mut[i] = 0; m_pulse[i] = 0; m_err[i] = 0;
         end else if (n == 0) begin
            m_pulse[i] = 0; m_err[i] = 0;
            if (!stk) m_mut[i] = 0;
         end else if (n > 1) begin
            m_n[i] = 0; m_prog[i] = 0; m_err[i] = 1; m_pulse[i] = 0;
            if (!stk) m_mut[i] = 0;
         end else begin
            sym = stb[0] ? 0 : stb[1] ? 1 : stb[2] ? 2 : 3;
            if (m_n[i] == 4) begin
               for (int j = 0; j < 3; j++) m_s[i][j] = m_s[i][j+1];
               m_s[i][3] = sym;
            end else begin
               m_s[i][m_n[i]] = sym;
               m_n[i]++;
            end
            hit = (m_n[i] == 4);
            for (int j = 0; j < 4; j++)
               if (m_s[i][j] != int'(m_pat[i][2*j +: 2])) hit = 0;
            m_pulse[i] = hit; m_err[i] = 0;
            if (hit && m_cnt[i] < m_max[i]) m_cnt[i]++;
            m_mut[i] = stk ? (m_mut[i] | hit) : hit;
            if (hit && !m_ovl[i]) m_n[i] = 0;
            m_prog[i] = 0;
            lim = (m_n[i] < 3) ? m_n[i] : 3;
            for (int k = 1; k <= lim; k++) begin
               ok = 1;
               for (int j = 0; j < k; j++)
                  if (m_s[i][m_n[i]-k+j] != int'(m_pat[i][2*j +: 2])) ok = 0;
               if (ok) m_prog[i] = k;
            end
         end
      end
   endtask

   // Drive one clock's worth of inputs at the falling edge; expect the registered result
   // one rising edge later.
   task automatic step(input bit [3:0] stb, input bit ld, input logic [7:0] pat);
      exp_t e;
      @(negedge clk);
      {st, sg, sc, sa} = stb;
      load = ld; pattern = pat;
      model_step(stb, ld, pat, sticky);
      e.tag = cycnt + 1;
      for (int i = 0; i < 3; i++) begin
         e.mut[i] = m_mut[i]; e.pulse[i] = m_pulse[i]; e.err[i] = m_err[i];
         e.prog[i] = 3'(m_prog[i]); e.cnt[i] = 8'(m_cnt[i]);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      {st, sg, sc, sa} = 4'b0; load = 0;
   endtask

   task automatic feed(input string s);
      bit [3:0] v;
      for (int i = 0; i < s.len(); i++) begin
         case (s[i])
            "A":     v = 4'b0001;
            "C":     v = 4'b0010;
            "G":     v = 4'b0100;
            "T":     v = 4'b1000;
            "x":     v = 4'b1100;
            default: v = 4'b0000;
         endcase
         step(v, 1'b0, 8'h00);
      end
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].tag == cycnt) begin
         mon_e = sb.pop_front();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mut[i], pulse[i], err[i], prog[i], acnt[i]} !==
                {mon_e.mut[i], mon_e.pulse[i], mon_e.err[i], mon_e.prog[i], mon_e.cnt[i]}) begin
               failures++;
               $display("FAIL sb inst%0d cyc%0d got mut=%b pulse=%b err=%b prog=%0d cnt=%0d want mut=%b pulse=%b err=%b prog=%0d cnt=%0d",
                        i, cycnt, mut[i], pulse[i], err[i], prog[i], acnt[i],
                        mon_e.mut[i], mon_e.pulse[i], mon_e.err[i], mon_e.prog[i], mon_e.cnt[i]);
            end
         end
      end
   end

   task automatic test_reset();
      model_reset();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({mut[i], pulse[i], err[i], prog[i], acnt[i]} !== 16'h0) begin
            failures++;
            $display("FAIL reset inst%0d got %h want 0", i, {mut[i], pulse[i], err[i], prog[i], acnt[i]});
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_default_pattern();
      sticky = 1;
      feed("G.G.T.C...");
      checks++;
      if (cnt0 !== 8'd1 || mut[0] !== 1'b1) begin
         failures++;
         $display("FAIL default cnt=%0d mut=%b want 1 1", cnt0, mut[0]);
      end
   endtask

   task automatic test_overlap();
      step(4'b0000, 1'b1, 8'h22);
      feed("GAGAGA");
      checks++;
      if (cnt0 !== 8'd2 || cnt1 !== 8'd1) begin
         failures++;
         $display("FAIL overlap cnt_ovl=%0d cnt_novl=%0d want 2 1", cnt0, cnt1);
      end
   endtask

   task automatic test_error();
      step(4'b0000, 1'b1, 8'h7A);
      feed("GGx");
      checks++;
      if (err[0] !== 1'b1 || prog[0] !== 3'd0) begin
         failures++;
         $display("FAIL error err=%b prog=%0d want 1 0", err[0], prog[0]);
      end
      feed("TC");
      checks++;
      if (cnt0 !== 8'd0) begin
         failures++;
         $display("FAIL error_nomatch cnt=%0d want 0", cnt0);
      end
      feed("GGTC");
      checks++;
      if (cnt0 !== 8'd1 || pulse[0] !== 1'b1) begin
         failures++;
         $display("FAIL error_recover cnt=%0d pulse=%b want 1 1", cnt0, pulse[0]);
      end
   endtask

   task automatic test_nonsticky();
      sticky = 0;
      step(4'b0000, 1'b1, 8'h7A);
      for (int r = 0; r < 2; r++) begin
         feed("GGTC");
         checks++;
         if (mut[0] !== 1'b1 || pulse[0] !== 1'b1) begin
            failures++;
            $display("FAIL nonsticky_hi r=%0d mut=%b pulse=%b want 1 1", r, mut[0], pulse[0]);
         end
         feed(".");
         checks++;
         if (mut[0] !== 1'b0) begin
            failures++;
            $display("FAIL nonsticky_lo r=%0d mut=%b want 0", r, mut[0]);
         end
      end
      sticky = 1;
   endtask

   task automatic test_saturation();
      int sat_exp[5] = '{1, 2, 3, 3, 3};
      step(4'b0000, 1'b1, 8'h7A);
      for (int r = 0; r < 5; r++) begin
         feed("GGTC");
         checks++;
         if (cnt2 !== 2'(sat_exp[r])) begin
            failures++;
            $display("FAIL saturation r=%0d cnt=%0d want %0d", r, cnt2, sat_exp[r]);
         end
      end
   endtask

   task automatic test_load_strobe();
      step(4'b0100, 1'b1, 8'h22);
      feed("AGA");
      checks++;
      if (cnt0 !== 8'd0) begin
         failures++;
         $display("FAIL load_strobe cnt=%0d want 0", cnt0);
      end
      feed("GA");
      checks++;
      if (cnt0 !== 8'd1) begin
         failures++;
         $display("FAIL load_newpat cnt=%0d want 1", cnt0);
      end
   endtask

   task automatic test_async_reset();
      step(4'b0000, 1'b1, 8'h7A);
      feed("GGT");
      @(negedge clk);
      #2 rst = 1'b1;
      model_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({mut[i], pulse[i], err[i], prog[i], acnt[i]} !== 16'h0) begin
            failures++;
            $display("FAIL async_reset inst%0d got %h want 0", i, {mut[i], pulse[i], err[i], prog[i], acnt[i]});
         end
      end
      #1 rst = 1'b0;
      feed("C.");
      checks++;
      if (cnt0 !== 8'd0 || mut[0] !== 1'b0) begin
         failures++;
         $display("FAIL reset_discard cnt=%0d mut=%b want 0 0", cnt0, mut[0]);
      end
   endtask

   initial begin
      test_reset();
      test_default_pattern();
      test_overlap();
      test_error();
      test_nonsticky();
      test_saturation();
      test_load_strobe();
      test_async_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain left=%0d want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
